valve_sequencer: RTL and testbench
==================================

// Module: valve_sequencer
// PURPOSE
// - Multi-channel solenoid valve pulse-train generator; successor to the single-shot valve_driver.
// - Per channel: trigger -> (REPEAT+1) pulses of PULSE_LEN cycles, separated by GAP_LEN low cycles.
// - Adds programmable gap, retrigger mode, abort, and busy/done status.
// - Runs on clk_1mhz; trig/abort come from TriggerIn bits; lengths come from WireIns.
// PARAMETERS
// - NUM_CH   4   number of independent valve channels
// - LEN_W    24  width of pulse/gap length fields (clock cycles)
// - REP_W    4   width of repeat field; pulse count = rep+1
// - RETRIG   0   0: trig while busy is ignored; 1: trig while busy restarts the sequence
// PORTS
// - clk        in   1            system clock (clk_1mhz)
// - reset_n    in   1            asynchronous, active-low reset
// - trig       in   NUM_CH       per-channel start, single-cycle pulse
// - abort      in   NUM_CH       per-channel stop, single-cycle pulse
// - pulse_len  in   NUM_CH*LEN_W ch i at [i*LEN_W +: LEN_W]; on-time in cycles
// - gap_len    in   NUM_CH*LEN_W ch i at [i*LEN_W +: LEN_W]; off-time between pulses
// - rep        in   NUM_CH*REP_W ch i at [i*REP_W +: REP_W]; extra pulses after the first
// - valve_out  out  NUM_CH       registered valve drive, active high
// - busy       out  NUM_CH       high while the channel is not IDLE
// - done       out  NUM_CH       1-cycle pulse when a sequence completes normally
// BEHAVIOUR
// - Reset (async assert, sync release): all channels IDLE; valve_out=0, busy=0, done=0, counters=0.
// - Per-channel FSM IDLE/ON/GAP. Channels are fully independent; no shared state.
// - trig sampled at edge k in IDLE:
//   - latch pulse_len, gap_len, rep into shadow registers.
//   - Later input changes do not affect a running sequence.
//   - enter ON; valve_out=1 and busy=1 from cycle k+1.
// - ON holds exactly L cycles (L = latched pulse_len). Then:
//   - pulses remaining: enter GAP for max(G,1) cycles, then ON again.
//   - last pulse: enter IDLE; valve_out=0, busy=0, done=1 in the same cycle.
// - Pulse count is rep+1. rep=15 at REP_W=4 gives 16 pulses.
// - Counters are LEN_W wide; a max-value length runs 2^LEN_W-1 cycles and does not wrap.
// - L=0 at trig: no pulse. busy=0, done=1 at k+1, valve_out stays 0.
// - G=0: treated as a 1-cycle gap, so pulses always show distinct edges.
// - abort: channel goes IDLE at next edge; valve_out=0, busy=0; no done pulse.
// - abort and trig in the same cycle: abort wins; channel ends IDLE.
// - trig while busy:
//   - RETRIG=0: ignored.
//   - RETRIG=1: reload shadows, restart ON at k+1 with pulse count reset; no done for the aborted run.
// - trig arriving in the same cycle as done (last ON cycle): treated as busy, per RETRIG.
// - reset_n low mid-sequence: outputs clear immediately, asynchronously.
// TESTING
// - L=3,rep=0,trig@k -> valve_out=1 on k+1..k+3, 0 at k+4; done=1 only at k+4; busy=1 on k+1..k+3.
// - L=2,G=3,rep=2 -> valve_out 1,1,0,0,0,1,1,0,0,0,1,1 then 0; done once; exactly 3 rising edges.
// - L=5,rep=1, abort during 2nd cycle of the first pulse -> valve_out=0 next cycle; busy=0; no done.
// - RETRIG=0: trig during ON has no effect (total = L*(rep+1) high cycles).
//   RETRIG=1: same trig restarts, so the pulse is stretched to 2+L cycles when trig lands on its 2nd cycle.
// - L=0 trig -> done at k+1, valve_out never high; G=0 with rep=1,L=2 -> 1,1,0,1,1.
// - 4 channels triggered the same cycle with different L; reset_n pulsed mid-run -> all outputs 0
//   asynchronously; next trig starts clean.

Source files
------------

// File: rtl/valve_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : valve_sequencer
// Brief   : Multi-channel solenoid valve pulse-train generator (trig -> rep+1 pulses)
// Revision: 1.0
// ============================================================================
module valve_sequencer #(
    parameter int NUM_CH = 4,
    parameter int LEN_W  = 24,
    parameter int REP_W  = 4,
    parameter int RETRIG = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         trig,
    input  logic [NUM_CH-1:0]         abort,
    input  logic [NUM_CH*LEN_W-1:0]   pulse_len,
    input  logic [NUM_CH*LEN_W-1:0]   gap_len,
    input  logic [NUM_CH*REP_W-1:0]   rep,
    output logic [NUM_CH-1:0]         valve_out,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         done
);

    localparam bit c_RETRIG = (RETRIG != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t           r_state, w_state_nxt;
            logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
            logic [LEN_W-1:0] r_len, w_len_nxt;
            logic [LEN_W-1:0] r_gap, w_gap_nxt;
            logic [REP_W-1:0] r_rep, w_rep_nxt;
            logic [REP_W-1:0] r_pcnt, w_pcnt_nxt;
            logic             r_valve;
            logic             r_done, w_done_nxt;
            logic [LEN_W-1:0] w_in_len, w_in_gap;
            logic [REP_W-1:0] w_in_rep;
            logic             w_start;

            assign w_in_len = pulse_len[gi*LEN_W +: LEN_W];
            assign w_in_gap = gap_len[gi*LEN_W +: LEN_W];
            assign w_in_rep = rep[gi*REP_W +: REP_W];
            // A trig on the last ON cycle counts as "busy", so it only starts when retriggerable.
            assign w_start  = trig[gi] && ((r_state == S_IDLE) || c_RETRIG);

            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                w_len_nxt   = r_len;
                w_gap_nxt   = r_gap;
                w_rep_nxt   = r_rep;
                w_pcnt_nxt  = r_pcnt;
                w_done_nxt  = 1'b0;
                if (abort[gi]) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_pcnt_nxt  = '0;
                end else if (w_start) begin
                    w_len_nxt  = w_in_len;
                    w_gap_nxt  = w_in_gap;
                    w_rep_nxt  = w_in_rep;
                    w_pcnt_nxt = '0;
                    if (w_in_len == '0) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_ON;
                        w_cnt_nxt   = w_in_len - 1'b1;
                    end
                end else begin
                    case (r_state)
                        S_ON: begin
                            if (r_cnt != '0) begin
                                w_cnt_nxt = r_cnt - 1'b1;
                            end else if (r_pcnt == r_rep) begin
                                w_state_nxt = S_IDLE;
                                w_pcnt_nxt  = '0;
                                w_done_nxt  = 1'b1;
                            end else begin
                                // Zero gap is stretched to one cycle so every pulse has edges.
                                w_state_nxt = S_GAP;
                                w_pcnt_nxt  = r_pcnt + 1'b1;
                                w_cnt_nxt   = (r_gap == '0) ? '0 : r_gap - 1'b1;
                            end
                        end
                        S_GAP: begin
                            if (r_cnt != '0) begin
                                w_cnt_nxt = r_cnt - 1'b1;
                            end else begin
                                w_state_nxt = S_ON;
                                w_cnt_nxt   = r_len - 1'b1;
                            end
                        end
                        default: begin
                            w_state_nxt = S_IDLE;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_len   <= '0;
                    r_gap   <= '0;
                    r_rep   <= '0;
                    r_pcnt  <= '0;
                    r_valve <= 1'b0;
                    r_done  <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_len   <= w_len_nxt;
                    r_gap   <= w_gap_nxt;
                    r_rep   <= w_rep_nxt;
                    r_pcnt  <= w_pcnt_nxt;
                    r_valve <= (w_state_nxt == S_ON);
                    r_done  <= w_done_nxt;
                end
            end

            assign valve_out[gi] = r_valve;
            assign busy[gi]      = (r_state != S_IDLE);
            assign done[gi]      = r_done;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_valve_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_valve_sequencer
// Brief   : Directed self-checking bench for valve_sequencer (RETRIG=0 and RETRIG=1)
// Revision: 1.0
// ============================================================================
module tb_valve_sequencer;

    localparam int c_LW = 8;
    localparam int c_RW = 4;

    logic        clk;
    logic        reset_n;
    logic [3:0]  trig_a, abort_a, valve_a, busy_a, done_a;
    logic [31:0] plen_a, glen_a;
    logic [15:0] rep_a;
    logic [0:0]  trig_b, abort_b, valve_b, busy_b, done_b;
    logic [7:0]  plen_b, glen_b;
    logic [3:0]  rep_b;

    int n_checks = 0;
    int n_errors = 0;

    valve_sequencer #(.NUM_CH(4), .LEN_W(c_LW), .REP_W(c_RW), .RETRIG(0)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .trig(trig_a), .abort(abort_a),
        .pulse_len(plen_a), .gap_len(glen_a), .rep(rep_a),
        .valve_out(valve_a), .busy(busy_a), .done(done_a)
    );

    valve_sequencer #(.NUM_CH(1), .LEN_W(c_LW), .REP_W(c_RW), .RETRIG(1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .trig(trig_b), .abort(abort_b),
        .pulse_len(plen_b), .gap_len(glen_b), .rep(rep_b),
        .valve_out(valve_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int ch, input int l, input int g, input int r);
        plen_a[ch*c_LW +: c_LW] = c_LW'(l);
        glen_a[ch*c_LW +: c_LW] = c_LW'(g);
        rep_a[ch*c_RW +: c_RW]  = c_RW'(r);
    endtask

    int pat2[13] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
    int pat7[6]  = '{1, 1, 0, 1, 1, 0};
    int lens[4]  = '{1, 2, 3, 4};

    initial begin
        int rises, highs, dones, done_at;
        logic prev;
        logic [3:0] expv, expd;

        reset_n = 1'b0;
        trig_a = '0; abort_a = '0; plen_a = '0; glen_a = '0; rep_a = '0;
        trig_b = '0; abort_b = '0; plen_b = '0; glen_b = '0; rep_b = '0;
        tick(); tick();
        chk("reset_valve", {28'd0, valve_a}, 0);
        chk("reset_busy",  {28'd0, busy_a},  0);
        chk("reset_done",  {28'd0, done_a},  0);
        reset_n = 1'b1;
        tick();

        // Single pulse L=3
        cfg(0, 3, 0, 0);
        trig_a[0] = 1'b1; tick(); trig_a[0] = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk("t1_valve", valve_a[0], (c <= 3));
            chk("t1_busy",  busy_a[0],  (c <= 3));
            chk("t1_done",  done_a[0],  (c == 4));
            tick();
        end

        // L=2 G=3 rep=2, inputs changed after trig must not matter
        cfg(1, 2, 3, 2);
        trig_a[1] = 1'b1; tick(); trig_a[1] = 1'b0;
        cfg(1, 7, 1, 5);
        rises = 0; dones = 0; prev = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            chk("t2_valve", valve_a[1], pat2[c-1]);
            chk("t2_done",  done_a[1],  (c == 13));
            if (valve_a[1] && !prev) rises++;
            if (done_a[1]) dones++;
            prev = valve_a[1];
            tick();
        end
        chk("t2_rises", rises, 3);
        chk("t2_dones", dones, 1);

        // Abort during 2nd cycle of first pulse
        cfg(2, 5, 2, 1);
        trig_a[2] = 1'b1; tick(); trig_a[2] = 1'b0;
        tick();
        abort_a[2] = 1'b1; tick(); abort_a[2] = 1'b0;
        chk("t3_valve", valve_a[2], 0);
        chk("t3_busy",  busy_a[2],  0);
        dones = 0; highs = 0;
        for (int c = 0; c < 15; c++) begin
            if (done_a[2]) dones++;
            if (valve_a[2]) highs++;
            tick();
        end
        chk("t3_nodone", dones, 0);
        chk("t3_nohigh", highs, 0);

        // RETRIG=0: trig during ON is ignored
        cfg(3, 4, 2, 1);
        trig_a[3] = 1'b1; tick(); trig_a[3] = 1'b0;
        highs = 0; dones = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 2) trig_a[3] = 1'b1;
            if (valve_a[3]) highs++;
            if (done_a[3]) dones++;
            tick();
            trig_a[3] = 1'b0;
        end
        chk("t4_highs", highs, 8);
        chk("t4_dones", dones, 1);

        // L=0: immediate done, no pulse
        cfg(0, 0, 0, 3);
        trig_a[0] = 1'b1; tick(); trig_a[0] = 1'b0;
        chk("t5_done",  done_a[0],  1);
        chk("t5_busy",  busy_a[0],  0);
        chk("t5_valve", valve_a[0], 0);
        tick();
        chk("t5_done2",  done_a[0],  0);
        chk("t5_valve2", valve_a[0], 0);

        // G=0 rep=1 L=2
        cfg(1, 2, 0, 1);
        trig_a[1] = 1'b1; tick(); trig_a[1] = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk("t6_valve", valve_a[1], pat7[c-1]);
            chk("t6_done",  done_a[1],  (c == 6));
            tick();
        end

        // abort and trig together in IDLE
        cfg(2, 4, 0, 0);
        trig_a[2] = 1'b1; abort_a[2] = 1'b1; tick(); trig_a[2] = 1'b0; abort_a[2] = 1'b0;
        chk("t7_busy",  busy_a[2],  0);
        chk("t7_valve", valve_a[2], 0);
        chk("t7_done",  done_a[2],  0);

        // rep=15 gives 16 pulses
        cfg(3, 1, 0, 15);
        trig_a[3] = 1'b1; tick(); trig_a[3] = 1'b0;
        rises = 0; done_at = 0; prev = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (valve_a[3] && !prev) rises++;
            if (done_a[3]) done_at = c;
            prev = valve_a[3];
            tick();
        end
        chk("t8_rises",   rises,   16);
        chk("t8_done_at", done_at, 32);

        // Max length does not wrap
        cfg(0, 255, 0, 0);
        trig_a[0] = 1'b1; tick(); trig_a[0] = 1'b0;
        highs = 0; done_at = 0;
        for (int c = 1; c <= 300; c++) begin
            if (valve_a[0]) highs++;
            if (done_a[0]) done_at = c;
            tick();
        end
        chk("t9_highs",   highs,   255);
        chk("t9_done_at", done_at, 256);

        // trig on the last ON cycle with RETRIG=0: completes normally
        cfg(0, 2, 0, 0);
        trig_a[0] = 1'b1; tick(); trig_a[0] = 1'b0;
        tick();
        trig_a[0] = 1'b1; tick(); trig_a[0] = 1'b0;
        chk("t10_valve", valve_a[0], 0);
        chk("t10_done",  done_a[0],  1);
        chk("t10_busy",  busy_a[0],  0);
        tick();

        // Four channels, different lengths, same trig cycle
        for (int i = 0; i < 4; i++) cfg(i, lens[i], 0, 0);
        trig_a = 4'hF; tick(); trig_a = '0;
        for (int c = 1; c <= 6; c++) begin
            for (int i = 0; i < 4; i++) begin
                expv[i] = (c <= lens[i]);
                expd[i] = (c == lens[i] + 1);
            end
            chk("t11_valve", {28'd0, valve_a}, {28'd0, expv});
            chk("t11_done",  {28'd0, done_a},  {28'd0, expd});
            tick();
        end

        // Asynchronous reset mid-run, then clean restart
        for (int i = 0; i < 4; i++) cfg(i, 10, 2, 3);
        trig_a = 4'hF; tick(); trig_a = '0;
        tick(); tick();
        chk("t12_pre_valve", {28'd0, valve_a}, 15);
        #2 reset_n = 1'b0;
        #1;
        chk("t12_rst_valve", {28'd0, valve_a}, 0);
        chk("t12_rst_busy",  {28'd0, busy_a},  0);
        chk("t12_rst_done",  {28'd0, done_a},  0);
        tick();
        reset_n = 1'b1;
        tick();
        cfg(0, 2, 0, 0);
        trig_a[0] = 1'b1; tick(); trig_a[0] = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk("t12_valve", {28'd0, valve_a}, (c <= 2) ? 1 : 0);
            chk("t12_done",  {28'd0, done_a},  (c == 3) ? 1 : 0);
            tick();
        end

        // RETRIG=1: trig on 2nd ON cycle stretches pulse to 2+L
        plen_b = 8'd3; glen_b = 8'd0; rep_b = 4'd0;
        trig_b = 1'b1; tick(); trig_b = 1'b0;
        highs = 0; done_at = 0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 2) trig_b = 1'b1;
            if (valve_b[0]) highs++;
            if (done_b[0]) done_at = c;
            tick();
            trig_b = 1'b0;
        end
        chk("t13_highs",   highs,   5);
        chk("t13_done_at", done_at, 6);

        // RETRIG=1: trig on last ON cycle restarts with no done
        plen_b = 8'd2;
        trig_b = 1'b1; tick(); trig_b = 1'b0;
        tick();
        trig_b = 1'b1; tick(); trig_b = 1'b0;
        chk("t14_valve", valve_b[0], 1);
        chk("t14_done",  done_b[0],  0);
        tick();
        chk("t14_valve2", valve_b[0], 1);
        tick();
        chk("t14_valve3", valve_b[0], 0);
        chk("t14_done3",  done_b[0],  1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
